// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack: program counter with a call/return stack, sticky stack-error flags, and a hardware loop that exists only when SEQ_LOOP_EN is defined
module program_sequencer_stack #(
    parameter int PC_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LOOP_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic jmp,
    input  logic jmp_nz,
    input  logic zero_flag,
    input  logic call,
    input  logic ret,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic loop_start,
    input  logic [LOOP_W-1:0] loop_cnt,
    input  logic loop_end,
    output logic [PC_W-1:0] pm_address,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
    output logic stack_ovf,
    output logic stack_unf
);
    localparam int LVL_W = $clog2(STACK_DEPTH+1);
    localparam int STK_W = STACK_DEPTH * PC_W;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(STACK_DEPTH);
    logic [STK_W-1:0] stack;
    logic [PC_W-1:0] pc_inc, pc_next, loop_addr;
    logic full, empty, jump, redirect, push, pop, loop_back;
    assign pc_inc = pm_address + PC_W'(1);
    assign full = stack_level == FULL;
    assign empty = stack_level == '0;
    assign jump = call | jmp | (jmp_nz & ~zero_flag);
    assign redirect = ret | jump;
    assign push = ~ret & call & ~full;
    assign pop = ret & ~empty;
`ifdef SEQ_LOOP_EN
    logic loop_active;
    logic [LOOP_W-1:0] loop_count;
    assign loop_back = ~redirect & loop_end & loop_active & (loop_count != '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_active <= 1'b0;
            loop_count <= '0;
            loop_addr <= '0;
        end else if (!redirect) begin
            if (loop_start) begin
                loop_active <= 1'b1;
                loop_count <= loop_cnt;
                loop_addr <= pc_inc;
            end else if (loop_end && loop_active) begin
                loop_active <= loop_back;
                loop_count <= loop_back ? loop_count - LOOP_W'(1) : loop_count;
            end
        end
    end
`else
    logic loop_unused;
    assign loop_unused = ^{loop_start, loop_cnt, loop_end};
    assign loop_back = 1'b0;
    assign loop_addr = '0;
`endif
    // top of stack lives in the low PC_W bits; push shifts up, pop shifts down
    always_comb begin
        pc_next = pop ? stack[PC_W-1:0] : ret ? pc_inc : jump ? jmp_addr : loop_back ? loop_addr : pc_inc;
    end
    always_ff @(posedge clk) begin
        if (push)
            stack <= (stack << PC_W) | STK_W'(pc_inc);
        else if (pop)
            stack <= stack >> PC_W;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_address <= '0;
            stack_level <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            pm_address <= pc_next;
            stack_level <= push ? stack_level + LVL_W'(1) : pop ? stack_level - LVL_W'(1) : stack_level;
            stack_ovf <= stack_ovf | (~ret & call & full);
            stack_unf <= stack_unf | (ret & empty);
        end
    end
endmodule
